prio_event_encoder: RTL and testbench

//  Parametrised, registered priority encoder with event latching and valid/ready output.

---
 rtl/prio_enc_pkg.sv | 23 ++
 rtl/prio_event_encoder_if.sv | 17 +
 rtl/prio_enc_comb.sv | 21 ++
 rtl/prio_event_encoder.sv | 88 ++++++++
 tb/tb_prio_event_encoder.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/prio_enc_pkg.sv
// Shared helpers for the priority event encoder: index-width derivation and one-hot decode.
package prio_enc_pkg;

  localparam int unsigned MAX_N = 256;

  function automatic int unsigned clog2_n(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) w = i + 1;
    end
    return w;
  endfunction

  localparam int unsigned N_DEF     = 8;
  localparam int unsigned IDX_W_DEF = clog2_n(N_DEF);

  // Callers size-cast the result down to their own N.
  function automatic logic [MAX_N-1:0] onehot(input int unsigned idx);
    return {{(MAX_N-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/prio_event_encoder_if.sv
// Downstream valid/ready channel carrying the selected index and the any-pending tag.
interface prio_event_encoder_if
  import prio_enc_pkg::*;
#(
  parameter int unsigned N = 8
);
  localparam int unsigned IDX_W = clog2_n(N);

  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_tag;

  modport master (output out_valid, output out_idx, output out_tag, input out_ready);
  modport slave  (input out_valid, input out_idx, input out_tag, output out_ready);

endinterface

// File: rtl/prio_enc_comb.sv
// Combinational N-to-IDX_W encoder: highest set bit wins, index 0 when the vector is empty.
module prio_enc_comb
  import prio_enc_pkg::*;
#(
  parameter int unsigned N = 8,
  localparam int unsigned IDX_W = clog2_n(N)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    any = |vec;
  end

endmodule

// File: rtl/prio_event_encoder.sv
// Registered priority encoder with request latching, sticky overflow and valid/ready output.
// Define PRIO_RR_EN for round-robin selection instead of fixed highest-index priority.
module prio_event_encoder
  import prio_enc_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [N-1:0]        req_i,
  prio_event_encoder_if.master dn,
  output logic                ovf_o,
  input  logic                ovf_clr
);

  localparam int unsigned IDX_W = clog2_n(N);

  logic [N-1:0]     pend;
  logic [N-1:0]     fmask;
  logic [N-1:0]     cand;
  logic [N-1:0]     set_v;
  logic             fire;
  logic             valid_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;

  assign fire  = valid_q & dn.out_ready;
  assign fmask = fire ? N'(onehot(32'(idx_q))) : '0;
  // Selection looks only at already-latched requests, minus the one leaving this cycle.
  assign cand  = pend & ~fmask;
  assign set_v = en ? req_i : '0;

`ifdef PRIO_RR_EN
  logic [IDX_W-1:0] rr_last;
  logic [IDX_W-1:0] rot_idx;
  logic [N-1:0]     rot;

  // Rotate so that rr_last-1 lands on the top bit, encode, then rotate the index back.
  always_comb begin
    rot = '0;
    for (int unsigned j = 0; j < N; j++) begin
      rot[j] = cand[IDX_W'((j + 32'(rr_last)) % N)];
    end
    enc_idx = IDX_W'((32'(rot_idx) + 32'(rr_last)) % N);
  end

  prio_enc_comb #(.N(N)) u_enc (
    .vec (rot),
    .idx (rot_idx),
    .any (enc_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) rr_last <= '0;
    else if (fire) rr_last <= idx_q;
  end
`else
  prio_enc_comb #(.N(N)) u_enc (
    .vec (cand),
    .idx (enc_idx),
    .any (enc_any)
  );
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend    <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      ovf_o   <= 1'b0;
    end else begin
      pend <= cand | set_v;
      if (!valid_q || fire) begin
        valid_q <= enc_any;
        idx_q   <= enc_any ? enc_idx : '0;
      end
      if (|(set_v & cand)) ovf_o <= 1'b1;
      else if (ovf_clr)    ovf_o <= 1'b0;
    end
  end

  assign dn.out_valid = valid_q;
  assign dn.out_idx   = idx_q;
  assign dn.out_tag   = |pend;

endmodule

// File: tb/tb_prio_event_encoder.sv
// Self-checking bench for prio_event_encoder (N=8); fired indices are checked against a queue
// of expected indices pushed by each scenario as it drives its requests.
module tb_prio_event_encoder;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         ovf_clr;
  logic         ovf_o;
  logic [N-1:0] req_i;

  prio_event_encoder_if #(.N(N)) bus ();

  prio_event_encoder #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req_i   (req_i),
    .dn      (bus),
    .ovf_o   (ovf_o),
    .ovf_clr (ovf_clr)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int unsigned exp_q[$];

  // Scoreboard: every accepted index must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_fire got idx=%0d want no fire", bus.out_idx);
      end else begin
        int unsigned e;
        e = exp_q.pop_front();
        if (32'(bus.out_idx) !== e) begin
          bad++;
          $display("FAIL sb_fire_idx got=%0d want=%0d", bus.out_idx, e);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b1; req_i = 8'hFF; ovf_clr = 1'b0; bus.out_ready = 1'b0;
    step(2);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_idx !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", bus.out_idx); end
    total++; if (bus.out_tag !== 1'b0) begin bad++; $display("FAIL reset_tag got=%b want=0", bus.out_tag); end
    total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf_o); end
    req_i = '0; rst_n = 1'b1;
    step(1);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_release_valid got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_basic;
    bus.out_ready = 1'b0;
    req_i = 8'h24;
    exp_q.push_back(5); exp_q.push_back(2);
    step(1);
    req_i = '0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_lat1_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_tag !== 1'b1) begin bad++; $display("FAIL basic_tag got=%b want=1", bus.out_tag); end
    step(1);
    total++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd5) begin bad++; $display("FAIL basic_first got v=%b idx=%0d want v=1 idx=5", bus.out_valid, bus.out_idx); end
    step(2);
    total++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd5) begin bad++; $display("FAIL basic_hold got v=%b idx=%0d want v=1 idx=5", bus.out_valid, bus.out_idx); end
    bus.out_ready = 1'b1;
    step(1);
    total++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd2) begin bad++; $display("FAIL basic_second got v=%b idx=%0d want v=1 idx=2", bus.out_valid, bus.out_idx); end
    step(1);
    total++; if (bus.out_valid !== 1'b0 || bus.out_tag !== 1'b0) begin bad++; $display("FAIL basic_drain got v=%b tag=%b want v=0 tag=0", bus.out_valid, bus.out_tag); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_stall_priority;
    bus.out_ready = 1'b0;
    req_i = 8'h04;
    exp_q.push_back(2); exp_q.push_back(7);
    step(1);
    req_i = '0;
    step(1);
    req_i = 8'h80;
    step(1);
    req_i = '0;
    step(2);
    total++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd2) begin bad++; $display("FAIL stall_hold got v=%b idx=%0d want v=1 idx=2", bus.out_valid, bus.out_idx); end
    bus.out_ready = 1'b1;
    step(1);
    total++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd7) begin bad++; $display("FAIL stall_next got v=%b idx=%0d want v=1 idx=7", bus.out_valid, bus.out_idx); end
    step(1);
    bus.out_ready = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_overflow;
    bus.out_ready = 1'b0;
    req_i = 8'h08;
    exp_q.push_back(3); exp_q.push_back(3);
    step(1);
    total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL ovf_first_req got=%b want=0", ovf_o); end
    step(1);
    req_i = '0;
    total++; if (ovf_o !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", ovf_o); end
    step(2);
    total++; if (ovf_o !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", ovf_o); end
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b want=0", ovf_o); end
    // Accept idx 3 while re-requesting it: no overflow, line re-presented after one bubble.
    bus.out_ready = 1'b1; req_i = 8'h08;
    step(1);
    bus.out_ready = 1'b0; req_i = '0;
    total++; if (ovf_o !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_tag !== 1'b1) begin bad++; $display("FAIL ovf_refire got ovf=%b v=%b tag=%b want ovf=0 v=0 tag=1", ovf_o, bus.out_valid, bus.out_tag); end
    step(1);
    total++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd3) begin bad++; $display("FAIL ovf_represent got v=%b idx=%0d want v=1 idx=3", bus.out_valid, bus.out_idx); end
    bus.out_ready = 1'b1;
    step(1);
    bus.out_ready = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ovf_drain got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_enable;
    en = 1'b0; req_i = 8'hFF; bus.out_ready = 1'b0;
    step(4);
    req_i = '0; en = 1'b1;
    total++; if (bus.out_tag !== 1'b0 || bus.out_valid !== 1'b0 || ovf_o !== 1'b0) begin bad++; $display("FAIL enable_off got tag=%b v=%b ovf=%b want 0 0 0", bus.out_tag, bus.out_valid, ovf_o); end
    step(2);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL enable_after got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_back_to_back;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
`ifdef PRIO_RR_EN
      exp_q.push_back(32'(7 - (i % 8)));
`else
      exp_q.push_back((i % 2 == 0) ? 32'd7 : 32'd6);
`endif
    end
    req_i = 8'hFF; bus.out_ready = 1'b1;
    step(2);
    total++; if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd7) begin bad++; $display("FAIL b2b_first got v=%b idx=%0d want v=1 idx=7", bus.out_valid, bus.out_idx); end
    step(10);
    req_i = '0; bus.out_ready = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_fires got pending=%0d want=0", exp_q.size()); end
    total++; if (ovf_o !== 1'b1 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_state got ovf=%b v=%b want ovf=1 v=1", ovf_o, bus.out_valid); end
  endtask

  task automatic test_reset_mid;
    rst_n = 1'b0; bus.out_ready = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(1);
    bus.out_ready = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.out_tag !== 1'b0 || ovf_o !== 1'b0) begin bad++; $display("FAIL midrst got v=%b tag=%b ovf=%b want 0 0 0", bus.out_valid, bus.out_tag, ovf_o); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL midrst_queue got pending=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall_priority();
    test_overflow();
    test_enable();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
